// File: rtl/writeback_stage.sv
// writeback_stage
//   Merges ALU results and memory-load results onto the register file's
//   single write port. ALU results are never stalled and always take the
//   port. Load results are buffered in a small FIFO behind a valid/ready
//   handshake. A younger ALU write cancels any queued load that targets the
//   same register. The write port (writeEnable/writeAddr/d) is registered.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   alu_valid/dest/data ALU result, accepted unconditionally
//   mem_valid/dest/data load result offer
//   mem_ready           load accepted when mem_valid & mem_ready
//   writeEnable         register file write strobe
//   writeAddr, d        register file write address / data
//   fifo_count          buffered entries, including cancelled ones
module writeback_stage #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  input  logic [ADDR_W-1:0]             alu_dest,
  input  logic [DATA_W-1:0]             alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [ADDR_W-1:0]             mem_dest,
  input  logic [DATA_W-1:0]             mem_data,
  output logic                          writeEnable,
  output logic [ADDR_W-1:0]             writeAddr,
  output logic [DATA_W-1:0]             d,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage: destination/data kept in arrays, the per-entry valid bits
  // live in a flop vector so every entry can be cancelled in parallel.
  logic [ADDR_W-1:0]     dest_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]     data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] valid_reg, valid_next;

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] d_reg, d_next;

  logic push;
  logic pop;
  logic head_valid;
  logic push_cancelled;

  // Ready depends only on occupancy; a pop in the same cycle does not free
  // a slot for reuse until the next cycle.
  assign mem_ready  = (count_reg != CNT_W'(FIFO_DEPTH));
  assign push       = mem_valid && mem_ready;
  // The head only gets the port when the ALU is idle.
  assign pop        = !alu_valid && (count_reg != '0);
  assign head_valid = valid_reg[rd_ptr_reg];
  // A load arriving alongside an ALU write to the same register is older,
  // so it is stored already cancelled.
  assign push_cancelled = alu_valid && (mem_dest == alu_dest);

  // Per-entry valid bit update: new loads, WAW cancellation, and pop.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    logic load_here;
    logic kill;
    logic popped_here;
    assign load_here   = push && (wr_ptr_reg == PTR_W'(gi));
    assign kill        = alu_valid && valid_reg[gi] && (dest_mem[gi] == alu_dest);
    assign popped_here = pop && (rd_ptr_reg == PTR_W'(gi));
    assign valid_next[gi] = load_here ? !push_cancelled :
                            (kill || popped_here) ? 1'b0 : valid_reg[gi];
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    we_next     = 1'b0;
    addr_next   = addr_reg;
    d_next      = d_reg;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    // Port arbitration: ALU, then a live head; a cancelled head is dropped
    // silently and address/data hold their previous value.
    if (alu_valid) begin
      we_next   = 1'b1;
      addr_next = alu_dest;
      d_next    = alu_data;
    end else if (pop && head_valid) begin
      we_next   = 1'b1;
      addr_next = dest_mem[rd_ptr_reg];
      d_next    = data_mem[rd_ptr_reg];
    end
  end

  // Payload storage needs no reset: an entry is only read while its slot is
  // counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[wr_ptr_reg] <= mem_dest;
      data_mem[wr_ptr_reg] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      d_reg      <= '0;
    end else begin
      valid_reg  <= valid_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      d_reg      <= d_next;
    end
  end

  assign writeEnable = we_reg;
  assign writeAddr   = addr_reg;
  assign d           = d_reg;
  assign fifo_count  = count_reg;

endmodule
